prime_reader: RTL and testbench

Consumer of the sieve's prime bitmap. Takes a snapshot of the `RANGE`-bit result vector, where bit k set means `START+k` is prime. Scans it low-to-high and streams each prime out as a binary number over a valid/ready handshake. Sits downstream of the sieve and feeds display, UART or checksum logic that needs primes as numbers rather than as a bitmap.

---
 rtl/prime_reader.sv | 124 ++++++++++++
 tb/tb_prime_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_reader.sv
// Streams the primes of a snapshotted sieve bitmap as ascending numbers over valid/ready.
// Optional per-scan emitted-prime counter on the prime_count port when PRIME_READER_COUNT_EN is defined.
module prime_reader #(
  parameter int RANGE = 10000,
  parameter int START = 100,
  parameter int NUM_W = 14,
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RANGE-1:0] bitmap,
  input  logic             start,
  output logic             busy,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic [NUM_W-1:0] prime_num,
  output logic             done
`ifdef PRIME_READER_COUNT_EN
  ,
  output logic [NUM_W-1:0] prime_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RANGE-1:0] r_snap;
  logic [IDX_W-1:0] r_idx;
  logic [NUM_W-1:0] r_num;
  logic             w_load;
  logic             w_adv;
  logic             w_emit;
  logic             w_hs;
  logic             w_bit;
  logic             w_last;

  assign w_bit  = r_snap[r_idx];
  assign w_last = (r_idx == IDX_W'(RANGE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_emit      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SCAN;
          w_load      = 1'b1;
        end
      end
      S_SCAN: begin
        if (w_bit) begin
          w_state_nxt = S_EMIT;
          w_emit      = 1'b1;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_adv = 1'b1;
        end
      end
      S_EMIT: begin
        // The last bit goes straight to DONE so idx never steps past RANGE-1.
        if (prime_ready) begin
          w_hs = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SCAN;
            w_adv       = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_load) r_snap <= bitmap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_num <= '0;
    end else begin
      if (w_load)     r_idx <= '0;
      else if (w_adv) r_idx <= r_idx + IDX_W'(1);
      if (w_emit)     r_num <= NUM_W'(START) + NUM_W'(r_idx);
    end
  end

`ifdef PRIME_READER_COUNT_EN
  logic [NUM_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (w_load) r_cnt <= '0;
    else if (w_hs)   r_cnt <= r_cnt + NUM_W'(1);
  end

  assign prime_count = r_cnt;
`endif

  // Valid is decoded from state so it never depends combinationally on prime_ready.
  assign busy        = (r_state == S_SCAN) || (r_state == S_EMIT);
  assign prime_valid = (r_state == S_EMIT);
  assign done        = (r_state == S_DONE);
  assign prime_num   = r_num;

endmodule

// File: tb/tb_prime_reader.sv
// Scoreboard bench for prime_reader: randomized bitmaps and backpressure against a bit-list model.
module tb_prime_reader;
  localparam int RANGE = 16;
  localparam int START = 100;
  localparam int NUM_W = 14;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             prime_ready = 1'b0;
  logic [RANGE-1:0] bitmap = '0;
  logic             busy;
  logic             prime_valid;
  logic             done;
  logic [NUM_W-1:0] prime_num;
`ifdef PRIME_READER_COUNT_EN
  logic [NUM_W-1:0] prime_count;
`endif

  prime_reader #(.RANGE(RANGE), .START(START), .NUM_W(NUM_W), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bitmap      (bitmap),
    .start       (start),
    .busy        (busy),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .prime_num   (prime_num),
    .done        (done)
`ifdef PRIME_READER_COUNT_EN
    ,
    .prime_count (prime_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int exp_cnt = 0;
  bit rdy_rand = 1'b0;
  bit rdy_hold = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ready driver: either held at rdy_hold or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    prime_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
  end

  // Monitor: pops the scoreboard on every handshake, checks protocol rules every cycle.
  initial begin
    logic             prev_v;
    logic             prev_r;
    logic             prev_done;
    logic [NUM_W-1:0] prev_num;
    prev_v = 1'b0; prev_r = 1'b0; prev_done = 1'b0; prev_num = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v    = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          check("hold_valid", prime_valid, 1);
          check("hold_num", prime_num, prev_num);
        end
        if (prime_valid && prime_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_prime: got %0d, expected none", prime_num);
          end else begin
            check("prime_num", prime_num, exp_q.pop_front());
          end
        end
        if (done) begin
          check("done_excl", {busy, prime_valid}, 0);
          check("done_single", prev_done, 0);
          check("missing_primes", exp_q.size(), 0);
`ifdef PRIME_READER_COUNT_EN
          check("prime_count", prime_count, exp_cnt);
`endif
        end
        prev_v    = prime_valid;
        prev_r    = prime_ready;
        prev_num  = prime_num;
        prev_done = done;
      end
    end
  end

  // Reference: every set bit k yields START+k, in ascending k order.
  task automatic start_scan(input logic [RANGE-1:0] bm);
    @(posedge clk);
    #1;
    bitmap  = bm;
    start   = 1'b1;
    exp_cnt = 0;
    for (int k = 0; k < RANGE; k++) begin
      if (bm[k]) begin
        exp_q.push_back(START + k);
        exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic wait_valid(input string name, input bit need_ready, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (prime_valid && (prime_ready || !need_ready)) break;
    end
    check(name, prime_valid && (prime_ready || !need_ready), 1);
  endtask

  initial begin
    logic [RANGE-1:0] bm;
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RANGE-1:0] bm;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", prime_valid, 0);
    check("rst_num", prime_num, 0);
    check("rst_done", done, 0);
`ifdef PRIME_READER_COUNT_EN
    check("rst_count", prime_count, 0);
`endif
    rst_n = 1'b1;

    // Bit 0 set: valid from the edge after start acceptance.
    rdy_rand = 1'b0; rdy_hold = 1'b1;
    start_scan(16'h0001);
    check("lat_busy_e0", busy, 1);
    check("lat_valid_e0", prime_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid_e1", prime_valid, 1);
    check("lat_num_e1", prime_num, START);
    wait_done(100);

    // 101, 103, 107, 109, 113 with ready held high.
    start_scan(16'h228A);
    wait_done(100);

    // Empty bitmap: done exactly in the cycle after E16.
    start_scan(16'h0000);
    repeat (RANGE - 1) @(posedge clk);
    #1;
    check("empty_done_e15", done, 0);
    @(posedge clk);
    #1;
    check("empty_done_e16", done, 1);

    // All bits set under random backpressure.
    rdy_rand = 1'b1;
    start_scan(16'hFFFF);
    wait_done(500);

    // Only the last bit: DONE straight from EMIT on the handshake.
    rdy_rand = 1'b0; rdy_hold = 1'b1;
    start_scan(16'h8000);
    wait_valid("last_bit_hs", 1'b1, 100);
    @(posedge clk);
    #1;
    check("last_bit_done", done, 1);
    check("last_bit_valid", prime_valid, 0);

    // Start re-pulsed mid-scan and through DONE with a changed bitmap.
    rdy_rand = 1'b1;
    bm = 16'($urandom);
    start_scan(bm);
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b1;
    bitmap = ~bm;
    wait_done(500);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("ignored_start_busy", busy, 0);
    check("ignored_start_done", done, 0);

    // Reset while holding a prime in EMIT.
    rdy_rand = 1'b0; rdy_hold = 1'b0;
    start_scan(16'h0421);
    wait_valid("rst_emit_reached", 1'b0, 100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_emit_valid", prime_valid, 0);
    check("rst_emit_busy", busy, 0);
    check("rst_emit_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_emit_no_done", done, 0);
    rst_n    = 1'b1;
    rdy_hold = 1'b1;
`ifdef PRIME_READER_COUNT_EN
    check("rst_emit_count", prime_count, 0);
`endif
    start_scan(16'h0421);
    wait_done(100);

    // Randomized bitmaps and ready modes.
    for (int t = 0; t < 20; t++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      rdy_hold = 1'b1;
      bm = 16'($urandom);
      start_scan(bm);
      wait_done(500);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
